weight_fetch_biu: RTL and testbench
===================================

# weight_fetch_biu

Bus-interface sequencer that fetches one output channel's kernel weights from external memory and writes them, one 32-bit word per beat, into the MAC-array weight load unit. It sits directly upstream of the weight load unit. It generates the encoded `weight_waddr` that selects kernel type, output channel, 3x3 tap offset and input-channel lane. A small in-order response FIFO decouples memory latency from the write stream.

## Interface
- `FIFO_DEPTH`, default 4: response FIFO entries; also the cap on outstanding requests plus buffered words (power of 2, ≥2).
- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle job launch; sampled only in IDLE.
- `base_addr` in 32: byte address of the job's first weight word; word-aligned.
- `mode_1x1` in 1: 1 = 1x1 kernel (16 words); 0 = 3x3 kernel (144 words).
- `out_ch` in 8: output channel index, copied into `waddr[30:23]`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse after the last weight write.
- `mem_req` out 1: read request valid.
- `mem_addr` out 32: read byte address.
- `mem_gnt` in 1: request accepted this cycle when `mem_req` is high.
- `mem_rvalid` in 1: read data valid; responses return in order, at least 1 cycle after grant.
- `mem_rdata` in 32: read data.
- `weight_waddr` out 32: encoded weight address (see Operation).
- `weight_wdata` out 32: weight word.
- `weight_wen` out 1: write strobe.

## Operation
- **Start:** an accepted `start` latches `base_addr`, `mode_1x1` and `out_ch`. `start` while busy is ignored.
- **Word order:** word index k runs 0..N-1 (N = 144 or 16).
  - Tap offset `off` = k/16 runs 0..8 (always 0 for 1x1).
  - Input channel `ic` = k%16.
  - `ic` is the inner loop.
- **Memory address:** `mem_addr` = `base_addr` + 4·k, 32-bit wrap.
- **waddr encoding** when `weight_wen`=1:
  - `[31]` = `mode_1x1`
  - `[30:23]` = `out_ch`
  - `[22:10]` = 0
  - `[9:6]` = `off`
  - `[5:4]` = 0
  - `[3:0]` = `ic`
- **Idle outputs:** when `weight_wen`=0, `weight_waddr` and `weight_wdata` are driven to 0. This is mandatory: the downstream block toggles its ping-pong bank on any cycle with `waddr[31]`=1 and `[3:0]`=15, write or not.
- **Bank toggle:** each 1x1 job therefore toggles the downstream bank exactly once, at `ic`=15. A 3x3 job never toggles it.
- **Credit rule:** issue a request only if outstanding + FIFO occupancy < `FIFO_DEPTH`. Outstanding is incremented on grant and decremented on `rvalid`. Simultaneous grant and `rvalid` leave it unchanged.
- **FIFO:** each `rvalid` pushes `rdata`. The FIFO can never overflow under the credit rule. A pop occurs every cycle the FIFO is non-empty; there is no downstream backpressure.
- **State machine:**
  - IDLE → FETCH on `start`.
  - FETCH → DRAIN when request N-1 is granted.
  - DRAIN → IDLE when write N-1 is issued; `done` pulses in the following cycle.
- **Reset or stray data:** `rst_n` low mid-job aborts immediately. `mem_rvalid` received in IDLE, for example stale responses after a reset, is dropped and never written.

## Timing
- **Reset values:** all outputs 0. Counters, FIFO pointers and the outstanding count are 0. State is IDLE.
- **Start:** `start` at cycle t. `busy`=1 and the first `mem_req` at t+1.
- **Request hold:** `mem_req`/`mem_addr` stay stable until `mem_gnt`. The next address may be presented in the cycle after a grant, or in the same registered update, so back-to-back grants reach 1 request/cycle.
- **Write latency:** `rvalid` at cycle r → `weight_wen` at r+1 (registered pop). This holds when the FIFO is empty.
- **Throughput:** sustained 1 write/cycle when round-trip latency ≤ `FIFO_DEPTH`-1 cycles.
- **Completion:** last write at cycle w → `done`=1 and `busy`=0 at w+1. A new `start` is accepted from w+1.

## Test plan
- **3x3 job:** `start`, `mode_1x1`=0, `out_ch`=5, `base_addr`=0x1000, zero-stall memory with 1-cycle latency.
  - Expect 144 writes. First `waddr`=0x0280_0000; last `waddr`=0x0280_020F, with `mem_addr`=0x123C.
  - Expect `done` one cycle after the last write and no write with `waddr[31]`=1.
- **1x1 job:** `out_ch`=0xFF.
  - Expect 16 writes, `waddr` 0xFF80_0000..0xFF80_000F.
  - Expect `waddr`=0 in all non-write cycles, and `busy` low after `done`.
- **Grant stalls:** `mem_gnt` random 30%.
  - Expect `mem_addr` stable while `mem_req` is ungranted, no skipped or duplicated k, and data order equal to memory order.
- **Long latency:** 8-cycle latency, `FIFO_DEPTH`=4.
  - Expect outstanding never above 4, no overflow, correct 144-word stream.
- **`start` while busy:** pulse `start` mid-job with different `out_ch`.
  - Expect it ignored and all 144 writes carrying the original `out_ch`.
- **Reset mid-job:** assert `rst_n` low at write 50, then inject 3 stray `rvalid` in IDLE.
  - Expect all outputs 0, no writes, and a subsequent job that completes normally.

Source files
------------

// File: rtl/weight_fetch_biu.sv
// Weight fetch bus-interface sequencer: streams one output channel's kernel weights from memory
// into the weight load unit through a small in-order response FIFO with credit-based issue.
module weight_fetch_biu #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        mode_1x1,
    input  logic [7:0]  out_ch,
    output logic        busy,
    output logic        done,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] weight_waddr,
    output logic [31:0] weight_wdata,
    output logic        weight_wen
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DepthW = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

    state_e        state_q;
    logic          mode_q;
    logic [7:0]    och_q;
    logic [7:0]    req_k_q;
    logic [7:0]    wr_k_q;
    logic [CW-1:0] outst_q;
    logic [CW-1:0] occ_q;
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [31:0]   fifo_mem [FIFO_DEPTH];

    logic [7:0]    n_words;
    logic          rv_ok;
    logic          gnt_ok;
    logic          fifo_nonempty;
    logic          pop_en;
    logic          push_en;
    logic [31:0]   pop_data;
    logic [CW-1:0] outst_d;
    logic [CW-1:0] occ_d;
    logic [CW:0]   credit_sum;
    logic          credit_ok;
    logic          last_req;
    logic          last_wr;

    always_comb begin
        n_words       = mode_q ? 8'd16 : 8'd144;
        // Responses arriving while idle are leftovers from an aborted job.
        rv_ok         = mem_rvalid && (state_q != StIdle);
        gnt_ok        = mem_req && mem_gnt;
        fifo_nonempty = (occ_q != '0);
        // An empty FIFO lets the response bypass straight to the write register.
        pop_en        = fifo_nonempty || rv_ok;
        push_en       = rv_ok && fifo_nonempty;
        pop_data      = fifo_nonempty ? fifo_mem[rptr_q] : mem_rdata;
        outst_d       = outst_q + CW'(gnt_ok) - CW'(rv_ok);
        occ_d         = occ_q + CW'(push_en) - CW'(fifo_nonempty);
        credit_sum    = {1'b0, outst_d} + {1'b0, occ_d};
        credit_ok     = (credit_sum < DepthW);
        last_req      = (req_k_q == n_words - 8'd1);
        last_wr       = (wr_k_q == n_words);
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            fifo_mem[wptr_q] <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mode_q       <= 1'b0;
            och_q        <= 8'd0;
            req_k_q      <= 8'd0;
            wr_k_q       <= 8'd0;
            outst_q      <= '0;
            occ_q        <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= 32'd0;
            weight_waddr <= 32'd0;
            weight_wdata <= 32'd0;
            weight_wen   <= 1'b0;
        end else begin
            done         <= 1'b0;
            outst_q      <= outst_d;
            occ_q        <= occ_d;
            weight_wen   <= 1'b0;
            weight_waddr <= 32'd0;
            weight_wdata <= 32'd0;
            if (push_en) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (fifo_nonempty) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (pop_en) begin
                weight_wen   <= 1'b1;
                weight_waddr <= {mode_q, och_q, 13'd0, wr_k_q[7:4], 2'd0, wr_k_q[3:0]};
                weight_wdata <= pop_data;
                wr_k_q       <= wr_k_q + 8'd1;
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= StFetch;
                        mode_q   <= mode_1x1;
                        och_q    <= out_ch;
                        req_k_q  <= 8'd0;
                        wr_k_q   <= 8'd0;
                        busy     <= 1'b1;
                        mem_req  <= 1'b1;
                        mem_addr <= base_addr;
                    end
                end
                StFetch: begin
                    if (gnt_ok) begin
                        req_k_q <= req_k_q + 8'd1;
                        if (last_req) begin
                            mem_req <= 1'b0;
                            state_q <= StDrain;
                        end else begin
                            mem_req  <= credit_ok;
                            mem_addr <= mem_addr + 32'd4;
                        end
                    end else if (!mem_req) begin
                        mem_req <= credit_ok;
                    end
                end
                StDrain: begin
                    if (weight_wen && last_wr) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_fetch_biu.sv
// Directed bench for weight_fetch_biu: in-order memory model with configurable latency and
// grant probability, plus a write-stream monitor checked against spec-derived expectations.
module tb_weight_fetch_biu;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic        mode_1x1 = 1'b0;
    logic [7:0]  out_ch = 8'd0;
    logic        busy, done, mem_req, weight_wen;
    logic [31:0] mem_addr, weight_waddr, weight_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    weight_fetch_biu #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .mode_1x1    (mode_1x1),
        .out_ch      (out_ch),
        .busy        (busy),
        .done        (done),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .weight_waddr(weight_waddr),
        .weight_wdata(weight_wdata),
        .weight_wen  (weight_wen)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total = 0;

    // Job expectations and memory configuration
    logic [31:0] job_base = 32'd0;
    logic        job_mode = 1'b0;
    logic [7:0]  job_och = 8'd0;
    int          lat = 1;
    int          gnt_pct = 100;
    int          stray_n = 0;

    logic [31:0] pq_data[$];
    int unsigned pq_due[$];

    // Monitor statistics
    int          wr_n, addr_bad, data_bad, idle_bad, toggles, grant_n, gaddr_bad, hold_bad;
    int          max_pend, done_n;
    int unsigned last_wr_cyc, done_cyc, start_cyc;
    logic        busy_at_done;
    logic [31:0] first_waddr, last_waddr, last_gaddr, prev_addr;
    logic        prev_hold;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    function automatic logic [31:0] exp_waddr(input int k);
        logic [7:0] kk;
        kk = k[7:0];
        return {job_mode, job_och, 13'd0, kk[7:4], 2'd0, kk[3:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", name, got, exp);
    endtask

    task automatic clear_stats();
        wr_n = 0; addr_bad = 0; data_bad = 0; idle_bad = 0; toggles = 0; grant_n = 0;
        gaddr_bad = 0; hold_bad = 0; max_pend = 0; done_n = 0;
        last_wr_cyc = 0; done_cyc = 0; busy_at_done = 1'b1;
        first_waddr = 32'd0; last_waddr = 32'd0; last_gaddr = 32'd0;
        prev_hold = 1'b0; prev_addr = 32'd0;
    endtask

    // Memory model and monitor, both evaluated mid-cycle on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            pq_data.delete();
            pq_due.delete();
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata = 32'd0;
            prev_hold = 1'b0;
        end else begin
            if (weight_wen) begin
                if (weight_waddr !== exp_waddr(wr_n)) addr_bad++;
                if (weight_wdata !== mdata(job_base + 32'(4 * wr_n))) data_bad++;
                if (wr_n == 0) first_waddr = weight_waddr;
                last_waddr = weight_waddr;
                last_wr_cyc = cyc;
                wr_n++;
            end else if (weight_waddr !== 32'd0 || weight_wdata !== 32'd0) begin
                idle_bad++;
            end
            if (weight_waddr[31] && weight_waddr[3:0] == 4'hF) toggles++;
            if (done) begin
                done_n++;
                done_cyc = cyc;
                busy_at_done = busy;
            end
            if (prev_hold && (!mem_req || mem_addr !== prev_addr)) hold_bad++;
            mem_gnt = ($urandom_range(99) < gnt_pct);
            if (mem_req && mem_gnt) begin
                if (mem_addr !== job_base + 32'(4 * grant_n)) gaddr_bad++;
                grant_n++;
                last_gaddr = mem_addr;
                pq_data.push_back(mdata(mem_addr));
                pq_due.push_back(cyc + lat);
            end
            prev_hold = mem_req && !mem_gnt;
            prev_addr = mem_addr;
            if (pq_due.size() > 0 && pq_due[0] <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata = pq_data.pop_front();
                void'(pq_due.pop_front());
            end else if (stray_n > 0) begin
                mem_rvalid = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
                stray_n--;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata = 32'd0;
            end
            if (pq_due.size() > max_pend) max_pend = pq_due.size();
        end
    end

    task automatic start_job(input logic [31:0] b, input logic m, input logic [7:0] o,
                             input int l, input int p);
        job_base = b; job_mode = m; job_och = o; lat = l; gnt_pct = p;
        clear_stats();
        base_addr = b; mode_1x1 = m; out_ch = o; start = 1'b1; start_cyc = cyc;
        @(posedge clk); #2;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("req_after_start", mem_req, 1);
        chk("addr_after_start", mem_addr, b);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #2;
            if (done_n > 0) begin
                seen = 1;
                break;
            end
        end
        chk("done_seen", seen, 1);
        repeat (2) @(posedge clk);
        #2;
        chk("busy_after_done", busy, 0);
    endtask

    task automatic check_job(input int n, input logic [31:0] first, input logic [31:0] last,
                             input int tog);
        chk("write_count", wr_n, n);
        chk("grant_count", grant_n, n);
        chk("first_waddr", first_waddr, first);
        chk("last_waddr", last_waddr, last);
        chk("waddr_seq_errors", addr_bad, 0);
        chk("wdata_order_errors", data_bad, 0);
        chk("grant_addr_errors", gaddr_bad, 0);
        chk("req_hold_errors", hold_bad, 0);
        chk("idle_nonzero_cycles", idle_bad, 0);
        chk("bank_toggles", toggles, tog);
        chk("done_pulses", done_n, 1);
        chk("done_after_last_wr", done_cyc - last_wr_cyc, 1);
        chk("busy_at_done", busy_at_done, 0);
        chk("outstanding_within_depth", max_pend <= DEPTH, 1);
    endtask

    initial begin
        clear_stats();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_ctrl", {busy, done, mem_req, weight_wen}, 0);
        chk("reset_buses", mem_addr | weight_waddr | weight_wdata, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // 3x3 job, zero-stall 1-cycle memory
        start_job(32'h0000_1000, 1'b0, 8'h05, 1, 100);
        wait_done();
        check_job(144, 32'h0280_0000, 32'h0280_020F, 0);
        chk("last_mem_addr", last_gaddr, 32'h0000_123C);
        chk("job_3x3_cycles", done_cyc - start_cyc, 147);

        // 1x1 job
        start_job(32'h0002_0000, 1'b1, 8'hFF, 1, 100);
        wait_done();
        check_job(16, 32'hFF80_0000, 32'hFF80_000F, 1);
        chk("job_1x1_cycles", done_cyc - start_cyc, 19);

        // Grant stalls
        start_job(32'h0000_8000, 1'b0, 8'h12, 3, 30);
        wait_done();
        check_job(144, 32'h0900_0000, 32'h0900_020F, 0);

        // Long latency against the credit limit
        start_job(32'h0003_0000, 1'b0, 8'h40, 8, 100);
        wait_done();
        check_job(144, 32'h2000_0000, 32'h2000_020F, 0);
        chk("pipe_filled_to_depth", max_pend, DEPTH);

        // start while busy, with a base address that wraps
        start_job(32'hFFFF_FFC0, 1'b0, 8'h21, 2, 70);
        repeat (40) @(posedge clk);
        #2;
        start = 1'b1; out_ch = 8'h7E; mode_1x1 = 1'b1; base_addr = 32'd0;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done();
        check_job(144, 32'h1080_0000, 32'h1080_020F, 0);

        // Reset at write 50, then stray responses while idle
        start_job(32'h0000_4000, 1'b0, 8'h03, 2, 100);
        begin
            bit hit = 0;
            for (int i = 0; i < 2000; i++) begin
                @(posedge clk); #2;
                if (wr_n >= 50) begin
                    hit = 1;
                    break;
                end
            end
            chk("reached_write_50", hit, 1);
        end
        rst_n = 1'b0;
        @(posedge clk); #2;
        chk("midjob_reset_ctrl", {busy, done, mem_req, weight_wen}, 0);
        chk("midjob_reset_buses", mem_addr | weight_waddr | weight_wdata, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        begin
            int snap;
            snap = wr_n;
            stray_n = 3;
            repeat (8) @(posedge clk);
            #2;
            chk("stray_writes", wr_n - snap, 0);
            chk("stray_busy", busy, 0);
            chk("strays_consumed", stray_n, 0);
        end

        // Normal job after the abort
        start_job(32'h0000_0100, 1'b1, 8'h0A, 1, 100);
        wait_done();
        check_job(16, 32'h8500_0000, 32'h8500_000F, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
